// File: rtl/inst_decode_alu.sv
// Front half of the single-cycle datapath: instruction store and IR, MIPS-subset decoder, ALU.
module inst_decode_alu #(
  parameter int unsigned IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [31:0]        imem_wdata,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        rt_data,
  output logic [31:0]        inst,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [31:0]        imm_ext,
  output logic [25:0]        imm26,
  output logic [3:0]         alu_ctr,
  output logic               reg_dst,
  output logic               reg_wrt,
  output logic               mem_read,
  output logic               mem_wrt,
  output logic               mem_reg,
  output logic               alu_src,
  output logic               branch,
  output logic               jump,
  output logic [31:0]        alu_out,
  output logic               zf
);

  localparam int unsigned Depth = 1 << IMEM_AW;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnXor = 6'h26;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;
  localparam logic [3:0] AluXor = 4'b1101;

  logic [31:0]        mem [Depth];
  logic [IMEM_AW-1:0] fetch_addr;
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero_ext;
  logic [31:0]        alu_b;

  // Byte offset and bits above the store depth are dropped so the fetch wraps.
  assign fetch_addr = pc[IMEM_AW+1:2];

  logic unused_pc;
  assign unused_pc = ^{pc[31:IMEM_AW+2], pc[1:0]};

  // Program load port; the store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  // IR; a same-cycle load to the fetched word is seen only on the following fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst <= '0;
    end else begin
      inst <= mem[fetch_addr];
    end
  end

  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign imm26 = inst[25:0];

  // Logical immediates are zero-extended, everything else sign-extended.
  assign zero_ext = (op == OpAndi) || (op == OpOri);
  assign imm_ext  = zero_ext ? {16'h0000, inst[15:0]} : {{16{inst[15]}}, inst[15:0]};

  // Decoder; anything not recognised falls through as a NOP.
  always_comb begin
    reg_dst  = 1'b0;
    reg_wrt  = 1'b0;
    mem_read = 1'b0;
    mem_wrt  = 1'b0;
    mem_reg  = 1'b0;
    alu_src  = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    alu_ctr  = AluAnd;
    unique case (op)
      OpRtype: begin
        reg_dst = 1'b1;
        reg_wrt = 1'b1;
        unique case (funct)
          FnAdd:   alu_ctr = AluAdd;
          FnSub:   alu_ctr = AluSub;
          FnAnd:   alu_ctr = AluAnd;
          FnOr:    alu_ctr = AluOr;
          FnXor:   alu_ctr = AluXor;
          FnNor:   alu_ctr = AluNor;
          FnSlt:   alu_ctr = AluSlt;
          default: begin
            reg_dst = 1'b0;
            reg_wrt = 1'b0;
          end
        endcase
      end
      OpAddi: begin
        alu_src = 1'b1;
        reg_wrt = 1'b1;
        alu_ctr = AluAdd;
      end
      OpAndi: begin
        alu_src = 1'b1;
        reg_wrt = 1'b1;
        alu_ctr = AluAnd;
      end
      OpOri: begin
        alu_src = 1'b1;
        reg_wrt = 1'b1;
        alu_ctr = AluOr;
      end
      OpSlti: begin
        alu_src = 1'b1;
        reg_wrt = 1'b1;
        alu_ctr = AluSlt;
      end
      OpLw: begin
        alu_src  = 1'b1;
        reg_wrt  = 1'b1;
        mem_read = 1'b1;
        mem_reg  = 1'b1;
        alu_ctr  = AluAdd;
      end
      OpSw: begin
        alu_src = 1'b1;
        mem_wrt = 1'b1;
        alu_ctr = AluAdd;
      end
      OpBeq: begin
        branch  = 1'b1;
        alu_ctr = AluSub;
      end
      OpJ: begin
        jump = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_b = alu_src ? imm_ext : rt_data;

  // ALU; unassigned codes yield zero.
  always_comb begin
    alu_out = '0;
    case (alu_ctr)
      AluAnd:  alu_out = rs_data & alu_b;
      AluOr:   alu_out = rs_data | alu_b;
      AluAdd:  alu_out = rs_data + alu_b;
      AluSub:  alu_out = rs_data - alu_b;
      AluSlt:  alu_out = {31'b0, $signed(rs_data) < $signed(alu_b)};
      AluNor:  alu_out = ~(rs_data | alu_b);
      AluXor:  alu_out = rs_data ^ alu_b;
      default: alu_out = '0;
    endcase
  end

  assign zf = (alu_out == 32'h0);

endmodule

// File: tb/tb_inst_decode_alu.sv
// Scoreboard bench for inst_decode_alu: driver pushes model predictions, monitor compares.
module tb_inst_decode_alu;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   rs_data;
  logic [31:0]   rt_data;
  logic [31:0]   inst;
  logic [4:0]    rs, rt, rd;
  logic [31:0]   imm_ext;
  logic [25:0]   imm26;
  logic [3:0]    alu_ctr;
  logic          reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump;
  logic [31:0]   alu_out;
  logic          zf;

  inst_decode_alu #(.IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .rs_data(rs_data), .rt_data(rt_data), .inst(inst),
    .rs(rs), .rt(rt), .rd(rd), .imm_ext(imm_ext), .imm26(imm26), .alu_ctr(alu_ctr),
    .reg_dst(reg_dst), .reg_wrt(reg_wrt), .mem_read(mem_read), .mem_wrt(mem_wrt),
    .mem_reg(mem_reg), .alu_src(alu_src), .branch(branch), .jump(jump),
    .alu_out(alu_out), .zf(zf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs, rt, rd;
    logic [25:0] imm26;
    logic [31:0] imm_ext;
    logic [3:0]  alu_ctr;
    logic [7:0]  ctrl;     // {reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src, branch, jump}
    logic [31:0] alu_out;
    logic        zf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [1 << AW];
  logic [31:0] model_ir;
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference: classify the instruction into an operation, then do plain arithmetic.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] a,
                                 input logic [31:0] t);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] b;
    string       kind;
    op = w[31:26];
    fn = w[5:0];
    e.inst  = w;
    e.rs    = w[25:21];
    e.rt    = w[20:16];
    e.rd    = w[15:11];
    e.imm26 = w[25:0];
    e.imm_ext = (op == 6'h0C || op == 6'h0D) ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
    e.ctrl = 8'b0;
    kind = "and";
    case (op)
      6'h00: begin
        e.ctrl = 8'b1100_0000;
        case (fn)
          6'h20: kind = "add";
          6'h22: kind = "sub";
          6'h24: kind = "and";
          6'h25: kind = "or";
          6'h26: kind = "xor";
          6'h27: kind = "nor";
          6'h2A: kind = "slt";
          default: e.ctrl = 8'b0;
        endcase
      end
      6'h08: begin e.ctrl = 8'b0100_0100; kind = "add"; end
      6'h0C: begin e.ctrl = 8'b0100_0100; kind = "and"; end
      6'h0D: begin e.ctrl = 8'b0100_0100; kind = "or";  end
      6'h0A: begin e.ctrl = 8'b0100_0100; kind = "slt"; end
      6'h23: begin e.ctrl = 8'b0110_1100; kind = "add"; end
      6'h2B: begin e.ctrl = 8'b0001_0100; kind = "add"; end
      6'h04: begin e.ctrl = 8'b0000_0010; kind = "sub"; end
      6'h02: begin e.ctrl = 8'b0000_0001; kind = "and"; end
      default: ;
    endcase
    b = e.ctrl[2] ? e.imm_ext : t;
    case (kind)
      "add": begin e.alu_ctr = 4'b0010; e.alu_out = a + b; end
      "sub": begin e.alu_ctr = 4'b0110; e.alu_out = a - b; end
      "or":  begin e.alu_ctr = 4'b0001; e.alu_out = a | b; end
      "xor": begin e.alu_ctr = 4'b1101; e.alu_out = a ^ b; end
      "nor": begin e.alu_ctr = 4'b1100; e.alu_out = ~(a | b); end
      "slt": begin e.alu_ctr = 4'b0111; e.alu_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      default: begin e.alu_ctr = 4'b0000; e.alu_out = a & b; end
    endcase
    e.zf = (e.alu_out == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", name, n_vec, act, req);
    end
  endtask

  // Monitor: outputs are valid at the falling edge following each issued vector.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("inst", 128'(inst), 128'(e.inst));
      check("fields", 128'({rs, rt, rd, imm26}), 128'({e.rs, e.rt, e.rd, e.imm26}));
      check("imm_ext", 128'(imm_ext), 128'(e.imm_ext));
      check("ctrl", 128'({alu_ctr, reg_dst, reg_wrt, mem_read, mem_wrt, mem_reg, alu_src,
                          branch, jump}), 128'({e.alu_ctr, e.ctrl}));
      check("alu", 128'({alu_out, zf}), 128'({e.alu_out, e.zf}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    rs_data = a;
    rt_data = b;
    exp_q.push_back(model(model_ir, a, b));
    n_vec++;
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [31:0] w);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = w;
    step();
    imem_we = 1'b0;
    model_mem[addr] = w;
  endtask

  task automatic fetch(input logic [31:0] p);
    pc = p;
    step();
    model_ir = model_mem[p[AW+1:2]];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_ir = '0;
  endtask

  task automatic run(input logic [AW-1:0] addr, input logic [31:0] w,
                     input logic [31:0] a, input logic [31:0] b);
    load(addr, w);
    fetch({22'h0, addr, 2'b00});
    issue(a, b);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [5:0]  ops [10];
    logic [5:0]  fns [9];
    int          k;
    ops = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h21};
    r = $urandom();
    k = int'($urandom_range(0, 10));
    if (k < 10) r[31:26] = ops[k];
    if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 8)];
    return r;
  endfunction

  initial begin
    logic [31:0] w, a, b, r;
    logic [AW-1:0] addr;
    rst = 1'b1; pc = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    rs_data = '0; rt_data = '0; model_ir = '0;
    step();
    rst = 1'b0;
    model_ir = '0;
    issue(32'h0000_F0F0, 32'h0000_0FF0);

    run(8'd0, 32'h0022_1820, 32'd5, 32'd7);
    run(8'd1, 32'h0022_1822, 32'd9, 32'd9);
    run(8'd2, 32'h0022_182A, 32'hFFFF_FFFF, 32'd1);
    run(8'd3, 32'h2001_FFFF, 32'd0, 32'h1234_5678);
    run(8'd4, 32'h3401_FFFF, 32'h1234_0000, 32'd0);
    run(8'd5, 32'h8C85_0008, 32'h0000_0100, 32'hDEAD_BEEF);
    run(8'd6, 32'hAC85_0008, 32'h0000_0100, 32'hDEAD_BEEF);
    run(8'd7, 32'h1022_0003, 32'd42, 32'd42);
    run(8'd8, 32'h0810_0000, 32'hFF00_FF00, 32'h0F0F_0F0F);
    run(8'd9, 32'hFC22_1820, 32'd3, 32'd5);
    run(8'd10, 32'h0022_1800, 32'd3, 32'd5);

    // Address wrap: byte address 0x400 maps back to word 0.
    fetch(32'h0000_0400);
    issue(32'd1, 32'd2);

    // Same-word write and fetch: IR must see the previous contents.
    load(8'd20, 32'h0022_1825);
    pc = {22'h0, 8'd20, 2'b00};
    imem_we = 1'b1; imem_waddr = 8'd20; imem_wdata = 32'h0022_1826;
    step();
    imem_we = 1'b0;
    model_ir = model_mem[20];
    model_mem[20] = 32'h0022_1826;
    issue(32'h0000_00FF, 32'h0000_0F0F);
    fetch({22'h0, 8'd20, 2'b00});
    issue(32'h0000_00FF, 32'h0000_0F0F);

    // Reset mid-program clears IR but keeps the store.
    do_reset();
    issue(32'hFFFF_FFFF, 32'h0000_FFFF);
    fetch(32'h0);
    issue(32'd5, 32'd7);

    for (int i = 0; i < 300; i++) begin
      w = rand_inst();
      r = $urandom();
      addr = r[AW-1:0];
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      load(addr, w);
      r = $urandom();
      fetch({r[31:AW+2], addr, r[1:0]});
      issue(a, b);
    end

    step();
    step();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
